// File: rtl/uart_rx_fifo_if.sv
// Handshake and CPU-side signal bundle for uart_rx_fifo.
// slave = FIFO side, master = uart_rx / CPU bus side.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
) ();
  logic [7:0]             rx_data;
  logic                   rx_data_ready;
  logic                   rx_clear;
  logic                   rd_strobe;
  logic                   clr_ovf;
  logic [7:0]             fifo_data;
  logic [$clog2(DEPTH):0] count;
  logic                   empty;
  logic                   full;
  logic                   ovf;
  logic                   irq_n;

  modport slave (
    input  rx_data, rx_data_ready, rd_strobe, clr_ovf,
    output rx_clear, fifo_data, count, empty, full, ovf, irq_n
  );

  modport master (
    output rx_data, rx_data_ready, rd_strobe, clr_ovf,
    input  rx_clear, fifo_data, count, empty, full, ovf, irq_n
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between a uart_rx instance and a CPU data register: level handshake
// on the write side, synchronized falling-edge pop on the read side.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int IRQ_EN = 1
) (
  input  logic          sys_clk,
  input  logic          RESET_n,
  uart_rx_fifo_if.slave bus
);
  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [0:0]   S_IDLE   = 1'b0;
  localparam logic [0:0]   S_ACK    = 1'b1;

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of 2 in 2..256");
  end

  logic [0:0]    state_q, state_d;
  logic          rx_clear_q, rx_clear_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          irq_n_q, irq_n_d;
  // [0] metastable stage, [1] synchronized level, [2] history for edge detect
  logic [2:0]    rd_pipe_q, rd_pipe_d;
  logic [7:0]    mem [DEPTH];

  logic push, pop, ovf_set, full_w, empty_w;

  assign full_w  = (count_q == FULL_CNT);
  assign empty_w = (count_q == '0);

  always_comb begin
    state_d    = state_q;
    rx_clear_d = rx_clear_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    push       = 1'b0;
    ovf_set    = 1'b0;
    rd_pipe_d  = {rd_pipe_q[1:0], bus.rd_strobe};

    // Pop fires once the CPU has finished reading, so the head byte stays put
    // for the whole bus cycle; ignored when there is nothing to pop.
    pop = rd_pipe_q[2] & ~rd_pipe_q[1] & ~empty_w;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_data_ready) begin
          // full is the pre-pop value: a byte arriving on a freeing pop waits a cycle
          if (full_w) begin
            ovf_set = 1'b1;
          end else begin
            push       = 1'b1;
            rx_clear_d = 1'b1;
            state_d    = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (!bus.rx_data_ready) begin
          rx_clear_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        rx_clear_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    if (ovf_set)          ovf_d = 1'b1;
    else if (bus.clr_ovf) ovf_d = 1'b0;
    else                  ovf_d = ovf_q;

    irq_n_d = (IRQ_EN != 0) ? (count_d == '0) : 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (!RESET_n) begin
      state_q    <= S_IDLE;
      rx_clear_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      irq_n_q    <= 1'b1;
      rd_pipe_q  <= '0;
    end else begin
      state_q    <= state_d;
      rx_clear_q <= rx_clear_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      irq_n_q    <= irq_n_d;
      rd_pipe_q  <= rd_pipe_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge sys_clk) begin
    if (RESET_n && push) mem[wr_ptr_q] <= bus.rx_data;
  end

  assign bus.fifo_data = mem[rd_ptr_q];
  assign bus.count     = count_q;
  assign bus.empty     = empty_w;
  assign bus.full      = full_w;
  assign bus.ovf       = ovf_q;
  assign bus.irq_n     = irq_n_q;
  assign bus.rx_clear  = rx_clear_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed checks of uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;

  logic sys_clk = 1'b0;
  logic RESET_n = 1'b0;
  always #18 sys_clk = ~sys_clk;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bif ();
  uart_rx_fifo #(.DEPTH(DEPTH), .IRQ_EN(1)) dut (
    .sys_clk (sys_clk),
    .RESET_n (RESET_n),
    .bus     (bif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte queue, sticky flag, handshake-owed flag, scheduled pops.
  logic [7:0] mq[$];
  bit m_ovf, m_ack, prev_rd, hold_ready;
  int pops[$];
  int edge_n = 0;

  task automatic model_edge();
    bit pre_full, pre_empty, pop_now, set, do_push;
    if (!RESET_n) begin
      mq.delete(); pops.delete();
      m_ovf = 0; m_ack = 0;
      prev_rd = bif.rd_strobe;
    end else begin
      pop_now = 0;
      if (pops.size() > 0 && pops[0] == edge_n) begin
        pop_now = 1;
        void'(pops.pop_front());
      end
      pre_full  = (mq.size() == DEPTH);
      pre_empty = (mq.size() == 0);
      set = 0; do_push = 0;
      if (!m_ack) begin
        if (bif.rx_data_ready) begin
          if (pre_full) set = 1;
          else          do_push = 1;
        end
      end else if (!bif.rx_data_ready) begin
        m_ack = 0;
      end
      if (pop_now && !pre_empty) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(bif.rx_data);
        m_ack = 1;
      end
      if (set)               m_ovf = 1;
      else if (bif.clr_ovf)  m_ovf = 0;
      // CPU read ends: two synchronizer edges plus the detecting edge
      if (prev_rd && !bif.rd_strobe) pops.push_back(edge_n + 2);
      prev_rd = bif.rd_strobe;
    end
    edge_n++;
  endtask

  task automatic check_outputs();
    chk("count",    32'(bif.count),  32'(mq.size()));
    chk("empty",    32'(bif.empty),  32'(mq.size() == 0));
    chk("full",     32'(bif.full),   32'(mq.size() == DEPTH));
    chk("ovf",      32'(bif.ovf),    32'(m_ovf));
    chk("irq_n",    32'(bif.irq_n),  32'(mq.size() == 0));
    chk("rx_clear", 32'(bif.rx_clear), 32'(m_ack));
    if (mq.size() > 0) chk("fifo_data", 32'(bif.fifo_data), 32'(mq[0]));
  endtask

  // One clock: model at the edge, compare at the falling edge, then let the
  // uart side drop its ready once acknowledged.
  task automatic tick();
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
    check_outputs();
    if (!hold_ready && bif.rx_data_ready && bif.rx_clear) bif.rx_data_ready = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bit ok = 0;
    bif.rx_data = b;
    bif.rx_data_ready = 1'b1;
    for (int g = 0; g < 20; g++) begin
      tick();
      if (!bif.rx_data_ready) begin ok = 1; break; end
    end
    chk("push_ack_seen", 32'(ok), 32'd1);
    bif.rx_data_ready = 1'b0;
    tick();
  endtask

  task automatic pulse_rd();
    bif.rd_strobe = 1'b1;
    tick(); tick();
    bif.rd_strobe = 1'b0;
    repeat (4) tick();
  endtask

  logic [7:0] ref_bytes [DEPTH];

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int rd_left, rd_gap, pp, rp;
    bif.rx_data = 8'h00; bif.rx_data_ready = 1'b0;
    bif.rd_strobe = 1'b0; bif.clr_ovf = 1'b0;
    hold_ready = 0;

    // reset state
    RESET_n = 1'b0;
    repeat (3) tick();
    chk("rst_empty", 32'(bif.empty), 32'd1);
    chk("rst_irq_n", 32'(bif.irq_n), 32'd1);
    RESET_n = 1'b1;
    tick();

    // two bytes in, two reads out
    push_byte(8'h41);
    chk("irq_after_push", 32'(bif.irq_n), 32'd0);
    push_byte(8'h42);
    chk("head_41", 32'(bif.fifo_data), 32'h41);
    pulse_rd();
    chk("head_42", 32'(bif.fifo_data), 32'h42);
    chk("count_1", 32'(bif.count), 32'd1);
    pulse_rd();
    chk("count_0", 32'(bif.count), 32'd0);
    chk("irq_idle", 32'(bif.irq_n), 32'd1);

    // overflow: 16 fit, 17th is held until a pop frees a slot
    for (int b = 0; b < 16; b++) push_byte(8'(b));
    chk("full_16", 32'(bif.full), 32'd1);
    bif.rx_data = 8'h10; bif.rx_data_ready = 1'b1;
    repeat (3) tick();
    chk("held_rx_clear", 32'(bif.rx_clear), 32'd0);
    chk("held_ovf", 32'(bif.ovf), 32'd1);
    pulse_rd();
    ok = 0;
    for (int g = 0; g < 10; g++) begin
      if (!bif.rx_data_ready) begin ok = 1; break; end
      tick();
    end
    chk("held_taken", 32'(ok), 32'd1);
    tick();
    chk("count_16_again", 32'(bif.count), 32'd16);
    for (int k = 0; k < 16; k++) begin
      chk("drain_order", 32'(bif.fifo_data), 32'(k + 1));
      pulse_rd();
    end
    bif.clr_ovf = 1'b1; tick(); bif.clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(bif.ovf), 32'd0);

    // refill across the pointer wrap, collide clr_ovf with an overflow
    for (int k = 0; k < DEPTH; k++) begin
      ref_bytes[k] = 8'($urandom);
      push_byte(ref_bytes[k]);
    end
    bif.rx_data = 8'hA5; bif.rx_data_ready = 1'b1;
    tick();
    bif.clr_ovf = 1'b1; tick(); bif.clr_ovf = 1'b0;
    chk("set_beats_clr", 32'(bif.ovf), 32'd1);
    for (int k = 0; k < DEPTH; k++) begin
      chk("wrap_data", 32'(bif.fifo_data), 32'(ref_bytes[k]));
      pulse_rd();
    end
    chk("wrap_tail", 32'(bif.fifo_data), 32'hA5);
    bif.clr_ovf = 1'b1; tick(); bif.clr_ovf = 1'b0;
    chk("ovf_clr_alone", 32'(bif.ovf), 32'd0);

    // push and pop on the same edge at count 5
    for (int k = 0; k < 4; k++) push_byte(8'(8'h50 + k));
    chk("count_5", 32'(bif.count), 32'd5);
    bif.rd_strobe = 1'b1; tick(); tick();
    bif.rd_strobe = 1'b0; tick(); tick();
    bif.rx_data = 8'h77; bif.rx_data_ready = 1'b1;
    tick();
    chk("pushpop_count", 32'(bif.count), 32'd5);
    chk("pushpop_head", 32'(bif.fifo_data), 32'h50);
    tick();

    // pop while empty is ignored
    for (int k = 0; k < 5; k++) pulse_rd();
    chk("drained", 32'(bif.count), 32'd0);
    pulse_rd();
    chk("empty_pop_count", 32'(bif.count), 32'd0);
    push_byte(8'h3C);
    chk("empty_pop_ptr", 32'(bif.fifo_data), 32'h3C);

    // set ovf, bring count to 2, then reset in ACK with count 3
    for (int k = 0; k < 15; k++) push_byte(8'($urandom));
    bif.rx_data = 8'hEE; bif.rx_data_ready = 1'b1;
    tick(); tick();
    for (int g = 0; g < 40 && bif.count > 2; g++) pulse_rd();
    chk("count_2", 32'(bif.count), 32'd2);
    hold_ready = 1;
    bif.rx_data = 8'hC3; bif.rx_data_ready = 1'b1;
    for (int g = 0; g < 10 && !bif.rx_clear; g++) tick();
    chk("ack_count_3", 32'(bif.count), 32'd3);
    chk("ack_ovf", 32'(bif.ovf), 32'd1);
    RESET_n = 1'b0;
    tick();
    chk("rst_ack_count", 32'(bif.count), 32'd0);
    chk("rst_ack_clear", 32'(bif.rx_clear), 32'd0);
    chk("rst_ack_irq", 32'(bif.irq_n), 32'd1);
    chk("rst_ack_ovf", 32'(bif.ovf), 32'd0);
    RESET_n = 1'b1;
    tick();
    chk("recapture", 32'(bif.fifo_data), 32'hC3);
    hold_ready = 0;
    tick(); tick();

    // randomized traffic, alternating fill-heavy and drain-heavy phases
    rd_left = 0; rd_gap = 0;
    for (int i = 0; i < 6000; i++) begin
      pp = ((i / 500) % 2 == 0) ? 40 : 8;
      rp = ((i / 500) % 2 == 0) ? 6 : 30;
      if (!bif.rx_data_ready && !bif.rx_clear && $urandom_range(99) < pp) begin
        bif.rx_data = 8'($urandom);
        bif.rx_data_ready = 1'b1;
      end
      if (bif.rd_strobe) begin
        if (rd_left == 0) begin bif.rd_strobe = 1'b0; rd_gap = $urandom_range(3); end
        else rd_left--;
      end else if (rd_gap > 0) begin
        rd_gap--;
      end else if ($urandom_range(99) < rp) begin
        bif.rd_strobe = 1'b1; rd_left = $urandom_range(2);
      end
      bif.clr_ovf = ($urandom_range(99) < 3);
      if ($urandom_range(999) < 2) begin
        bif.rd_strobe = 1'b0; rd_left = 0; rd_gap = 2;
        RESET_n = 1'b0;
      end else begin
        RESET_n = 1'b1;
      end
      tick();
    end
    RESET_n = 1'b1; bif.clr_ovf = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
